// File: rtl/trdb_pkg.sv
// Shared types for the trace session controller: FSM states and packet kinds
// requested from the packet emitter.
package trdb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_SYNC  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_STOP  = 3'd5
  } trace_ctrl_state_e;

  typedef enum logic [1:0] {
    TPKT_START = 2'd0,
    TPKT_SYNC  = 2'd1,
    TPKT_STOP  = 2'd2
  } trace_pkt_e;

endpackage

// File: rtl/trdb_resync_cnt.sv
// Saturating retired-instruction counter; flags when the next sync packet is due.
// Clear wins over increment; a zero threshold never raises sync_due.
module trdb_resync_cnt #(
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_clr,
  input  logic                i_inc,
  input  logic [RESYNC_W-1:0] i_max,
  output logic                o_sync_due
);

  logic [RESYNC_W-1:0] r_cnt;
  logic [RESYNC_W:0]   w_sum;

  // One extra bit so a saturated count plus this cycle's retire cannot wrap.
  assign w_sum      = {1'b0, r_cnt} + {{RESYNC_W{1'b0}}, i_inc};
  assign o_sync_due = (i_max != '0) && (w_sum >= {1'b0, i_max});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(RESYNC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace session controller: start / run / periodic sync / drain / stop sequencing.
// Packet requests are held until acked; every start is eventually paired with a stop.
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_W     = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  localparam int unsigned DRAIN_W     = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                trace_activated_i,
  input  logic                trace_req_on_i,
  input  logic                trace_req_off_i,
  input  logic                retired_i,
  input  logic [RESYNC_W-1:0] resync_max_i,
  output logic                pkt_req_o,
  output trace_pkt_e          pkt_type_o,
  input  logic                pkt_ack_i,
  output logic                trace_enable_o,
  output logic                clk_en_o,
  output logic                busy_o
);

  trace_ctrl_state_e  r_state, w_state_nxt;
  logic               r_stop_pending;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               w_stop, w_sync_due, w_cnt_clr, w_cnt_inc, w_drain_ld;

  // On beats off when both arrive together, so a retrigger keeps the session alive.
  assign w_stop     = ~trace_activated_i | (trace_req_off_i & ~trace_req_on_i);
  assign w_cnt_inc  = retired_i & ((r_state == ST_RUN) | (r_state == ST_SYNC));
  assign w_drain_ld = (w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN);
  assign clk_en_o   = (r_state != ST_IDLE) | trace_activated_i;

  trdb_resync_cnt #(
    .RESYNC_W (RESYNC_W)
  ) u_resync_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .i_max      (resync_max_i),
    .o_sync_due (w_sync_due)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_clr      = 1'b0;
    pkt_req_o      = 1'b0;
    pkt_type_o     = TPKT_START;
    trace_enable_o = 1'b0;
    busy_o         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (trace_activated_i && trace_req_on_i) w_state_nxt = ST_START;
      end
      ST_START: begin
        pkt_req_o = 1'b1;
        if (pkt_ack_i) begin
          w_state_nxt = ST_RUN;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        trace_enable_o = 1'b1;
        if (w_stop) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_sync_due) begin
          w_state_nxt = ST_SYNC;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_SYNC: begin
        pkt_req_o      = 1'b1;
        pkt_type_o     = TPKT_SYNC;
        trace_enable_o = 1'b1;
        if (pkt_ack_i) w_state_nxt = (r_stop_pending || w_stop) ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        pkt_req_o  = 1'b1;
        pkt_type_o = TPKT_STOP;
        if (pkt_ack_i) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        busy_o      = 1'b0;
      end
    endcase
  end

  // A stop seen while the sync packet is outstanding must survive until it is acked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stop_pending <= 1'b0;
    end else if ((r_state == ST_STOP) && pkt_ack_i) begin
      r_stop_pending <= 1'b0;
    end else if ((r_state == ST_SYNC) && w_stop) begin
      r_stop_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drain_cnt <= '0;
    end else if (w_drain_ld) begin
      r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
    end
  end

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Directed bench for the trace session controller; outputs are compared as
// {pkt_req, pkt_type[1:0], trace_enable, busy, clk_en} one cycle at a time.
module tb_trdb_trace_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        act, on, off, ret, ack;
  logic [15:0] rmax;
  logic        req, ten, cen, busy;
  logic [1:0]  ptype;
  int          vec = 0;
  int          err = 0;

  always #5 clk_i = ~clk_i;

  trdb_trace_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .trace_activated_i (act),
    .trace_req_on_i    (on),
    .trace_req_off_i   (off),
    .retired_i         (ret),
    .resync_max_i      (rmax),
    .pkt_req_o         (req),
    .pkt_type_o        (ptype),
    .pkt_ack_i         (ack),
    .trace_enable_o    (ten),
    .clk_en_o          (cen),
    .busy_o            (busy)
  );

  function automatic logic [5:0] obs();
    return {req, ptype, ten, busy, cen};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst_ni = 1'b0; act = 1'b0; on = 1'b0; off = 1'b0; ret = 1'b0; ack = 1'b0; rmax = '0;
    repeat (2) @(posedge clk_i);
    #1;
    exp = 6'b000000; vec++;
    if (obs() !== exp) begin err++; $display("FAIL reset_state got=%b exp=%b", obs(), exp); end
    act = 1'b1; #1;
    exp = 6'b000001; vec++;
    if (obs() !== exp) begin err++; $display("FAIL reset_clken_act got=%b exp=%b", obs(), exp); end
    act = 1'b0; #1;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_start();
    logic [5:0] exp;
    act = 1'b1; #1;
    exp = 6'b000001; vec++;
    if (obs() !== exp) begin err++; $display("FAIL idle_activated got=%b exp=%b", obs(), exp); end
    on = 1'b1; step(); on = 1'b0;
    exp = 6'b100011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL start_c1 got=%b exp=%b", obs(), exp); end
    step();
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL start_c2 got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL run_entry got=%b exp=%b", obs(), exp); end
  endtask

  task automatic test_resync();
    logic [5:0] exp;
    rmax = 16'd5; ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = 6'b000111; vec++;
      if (obs() !== exp) begin err++; $display("FAIL resync_run_a%0d got=%b exp=%b", i, obs(), exp); end
    end
    step();
    exp = 6'b101111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL resync_sync1 got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL resync_back_run got=%b exp=%b", obs(), exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL resync_run_b%0d got=%b exp=%b", i, obs(), exp); end
    end
    step();
    exp = 6'b101111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL resync_sync2 got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0; ret = 1'b0; rmax = '0;
    exp = 6'b000111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL resync_run_end got=%b exp=%b", obs(), exp); end
  endtask

  task automatic test_on_off_together();
    logic [5:0] exp;
    on = 1'b1; off = 1'b1;
    exp = 6'b000111;
    for (int i = 0; i < 2; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL on_off_stay_run%0d got=%b exp=%b", i, obs(), exp); end
    end
    on = 1'b0; off = 1'b0;
  endtask

  task automatic test_sync_stop();
    logic [5:0] exp;
    rmax = 16'd1; step(); rmax = '0;
    exp = 6'b101111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_entry got=%b exp=%b", obs(), exp); end
    off = 1'b1; step(); off = 1'b0;
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_hold1 got=%b exp=%b", obs(), exp); end
    step();
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_hold2 got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_drain0 got=%b exp=%b", obs(), exp); end
    for (int i = 1; i < 4; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL syncstop_drain%0d got=%b exp=%b", i, obs(), exp); end
    end
    step();
    exp = 6'b110011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_stop got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000001; vec++;
    if (obs() !== exp) begin err++; $display("FAIL syncstop_idle got=%b exp=%b", obs(), exp); end
  endtask

  task automatic test_drain_off();
    logic [5:0] exp;
    on = 1'b1; step(); on = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    off = 1'b1; step(); off = 1'b0;
    exp = 6'b000011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL drain_c0 got=%b exp=%b", obs(), exp); end
    for (int i = 1; i < 4; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL drain_c%0d got=%b exp=%b", i, obs(), exp); end
    end
    step();
    exp = 6'b110011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL drain_stop got=%b exp=%b", obs(), exp); end
    on = 1'b1; step();
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL drain_stop_held got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0; on = 1'b0;
    exp = 6'b000001; vec++;
    if (obs() !== exp) begin err++; $display("FAIL drain_idle got=%b exp=%b", obs(), exp); end
  endtask

  task automatic test_deact_start();
    logic [5:0] exp;
    on = 1'b1; step(); on = 1'b0;
    act = 1'b0; #1;
    exp = 6'b100011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL deact_start_c1 got=%b exp=%b", obs(), exp); end
    step();
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL deact_start_c2 got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL deact_run got=%b exp=%b", obs(), exp); end
    exp = 6'b000011;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL deact_drain%0d got=%b exp=%b", i, obs(), exp); end
    end
    step();
    exp = 6'b110011; vec++;
    if (obs() !== exp) begin err++; $display("FAIL deact_stop got=%b exp=%b", obs(), exp); end
    ack = 1'b1; step(); ack = 1'b0;
    exp = 6'b000000; vec++;
    if (obs() !== exp) begin err++; $display("FAIL deact_idle got=%b exp=%b", obs(), exp); end
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    act = 1'b1;
    on = 1'b1; step(); on = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    rmax = 16'd1; ret = 1'b1; step();
    exp = 6'b101111; vec++;
    if (obs() !== exp) begin err++; $display("FAIL arst_pre_sync got=%b exp=%b", obs(), exp); end
    #2 rst_ni = 1'b0;
    #1;
    exp = 6'b000001; vec++;
    if (obs() !== exp) begin err++; $display("FAIL arst_async got=%b exp=%b", obs(), exp); end
    #2 rst_ni = 1'b1;
    ret = 1'b0; rmax = '0;
    step();
    vec++;
    if (obs() !== exp) begin err++; $display("FAIL arst_idle got=%b exp=%b", obs(), exp); end
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vec++;
      if (obs() !== exp) begin err++; $display("FAIL spurious_ack%0d got=%b exp=%b", i, obs(), exp); end
    end
    ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_resync();
    test_on_off_together();
    test_sync_stop();
    test_drain_off();
    test_deact_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
